axi4_lite_master_cmd: RTL

AXI4-Lite master that turns a simple valid/ready command port into single read or write transactions toward an AXI4-Lite slave, such as the tap-BRAM or configuration-register slaves. The channel set matches the codebase's AXI4-Lite slaves: AR, R, AW and W channels, with no B channel and no response codes. It drives the FIR block during bring-up and by on-chip loaders, and returns read data or write completion on a response port. One transaction is outstanding at a time.

---
 rtl/axi4_lite_pkg.sv | 16 +
 rtl/axi4_lite_master_cmd.sv | 106 ++++++++++
 2 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite command master and the AXI4-Lite slaves it talks to.
package axi4_lite_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RDATA,
    WADDR,
    WDATA,
    RSP
  } state_t;

  // Clears the two byte-offset bits so every access is word aligned.
  localparam logic [63:0] ADDR_ALIGN_MASK = ~64'h3;

endpackage

// File: rtl/axi4_lite_master_cmd.sv
// Turns a valid/ready command port into single AXI4-Lite read or write transactions.
// Only one transaction is outstanding at a time, and the result comes back on a response port.
module axi4_lite_master_cmd
  import axi4_lite_pkg::*;
#(
  parameter int pADDR_WIDTH = 32,
  parameter int pDATA_WIDTH = 32
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   in_cmd_valid,
  output logic                   out_cmd_ready,
  input  logic                   in_cmd_write,
  input  logic [pADDR_WIDTH-1:0] in_cmd_addr,
  input  logic [pDATA_WIDTH-1:0] in_cmd_wdata,
  output logic                   out_rsp_valid,
  input  logic                   in_rsp_ready,
  output logic [pDATA_WIDTH-1:0] out_rsp_rdata,
  output logic                   out_rsp_write,
  output logic [pADDR_WIDTH-1:0] out_m_araddr,
  output logic                   out_m_arvalid,
  input  logic                   in_m_arready,
  input  logic [pDATA_WIDTH-1:0] in_m_rdata,
  input  logic                   in_m_rvalid,
  output logic                   out_m_rready,
  output logic [pADDR_WIDTH-1:0] out_m_awaddr,
  output logic                   out_m_awvalid,
  input  logic                   in_m_awready,
  output logic [pDATA_WIDTH-1:0] out_m_wdata,
  output logic                   out_m_wvalid,
  input  logic                   in_m_wready,
  output logic                   out_busy
);

  localparam logic [pADDR_WIDTH-1:0] ALIGN_MASK = ADDR_ALIGN_MASK[pADDR_WIDTH-1:0];

  state_t                   state;
  state_t                   state_next;
  logic                     cmd_ready_q;
  logic                     cmd_fire;
  logic [pADDR_WIDTH-1:0]   addr_q;
  logic [pDATA_WIDTH-1:0]   wdata_q;
  logic                     write_q;
  logic [pDATA_WIDTH-1:0]   rdata_q;

  assign cmd_fire = in_cmd_valid && cmd_ready_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_fire) state_next = in_cmd_write ? WADDR : RADDR;
      RADDR:   if (in_m_arready) state_next = RDATA;
      RDATA:   if (in_m_rvalid) state_next = RSP;
      WADDR:   if (in_m_awready) state_next = WDATA;
      WDATA:   if (in_m_wready) state_next = RSP;
      RSP:     if (in_rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command ready is registered so it stays low while reset is asserted and
  // only rises on the cycle the FSM is actually back in IDLE.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cmd_ready_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      rdata_q     <= '0;
    end else begin
      cmd_ready_q <= (state_next == IDLE);
      if (cmd_fire) begin
        addr_q  <= in_cmd_addr & ALIGN_MASK;
        wdata_q <= in_cmd_wdata;
        write_q <= in_cmd_write;
      end
      if (state == RDATA && in_m_rvalid) begin
        rdata_q <= in_m_rdata;
      end else if (state == WDATA && in_m_wready) begin
        rdata_q <= '0;
      end
    end
  end

  assign out_cmd_ready = cmd_ready_q;
  assign out_busy      = (state != IDLE);
  assign out_m_arvalid = (state == RADDR);
  assign out_m_rready  = (state == RDATA);
  assign out_m_awvalid = (state == WADDR);
  assign out_m_wvalid  = (state == WDATA);
  assign out_rsp_valid = (state == RSP);
  assign out_m_araddr  = addr_q;
  assign out_m_awaddr  = addr_q;
  assign out_m_wdata   = wdata_q;
  assign out_rsp_rdata = rdata_q;
  assign out_rsp_write = write_q;

endmodule
